// File: rtl/axi_ctrl_write_queue.sv
// AXI4-Lite write path into a register bank: one-deep AW/W holding
// entries, slot decode at commit and an in-order B-response queue.
module axi_ctrl_write_queue #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REG = 5,
  parameter int C_NUM_REG_WIDTH = 3,
  parameter logic [C_NUM_REG*C_ADDR_WIDTH-1:0] C_REG_ADDR_ARRAY =
    160'h0000_f00C_0000_f008_0000_f004_0000_f000_FFFF_FFFF,
  parameter logic [C_NUM_REG-1:0] C_REG_WRAC_ARRAY = 5'b11111,
  parameter int C_BQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [C_ADDR_WIDTH-1:0]    awaddr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [C_DATA_WIDTH-1:0]    wdata,
  input  logic [C_DATA_WIDTH/8-1:0]  wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  output logic [C_NUM_REG_WIDTH-1:0] reg_data_sel,
  output logic                       reg_data_write,
  output logic [C_DATA_WIDTH-1:0]    reg_data,
  output logic [C_DATA_WIDTH/8-1:0]  reg_data_strb
);

  localparam int SW = C_DATA_WIDTH / 8;
  localparam int PW = $clog2(C_BQ_DEPTH) + 1;

  logic                       aw_full;
  logic [C_ADDR_WIDTH-1:0]    aw_addr_q;
  logic                       w_full;
  logic [C_DATA_WIDTH-1:0]    w_data_q;
  logic [SW-1:0]              w_strb_q;
  logic [1:0]                 bq_mem [C_BQ_DEPTH];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic                       bq_full;
  logic                       bq_empty;
  logic                       commit;
  logic                       pop;
  logic                       hit;
  logic                       hit_wr;
  logic [C_NUM_REG_WIDTH-1:0] hit_sel;
  logic [1:0]                 resp;
  logic                       do_write;

  assign awready  = ~aw_full;
  assign wready   = ~w_full;
  assign bq_empty = (wr_ptr == rd_ptr);
  assign bq_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign bvalid   = ~bq_empty;
  assign bresp    = bq_mem[rd_ptr[PW-2:0]];
  assign pop      = bvalid & bready;
  // Full is judged on the registered count; a same-cycle pop does not help.
  assign commit   = aw_full & w_full & ~bq_full;

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    hit     = 1'b0;
    hit_wr  = 1'b0;
    hit_sel = '0;
    for (int i = C_NUM_REG - 1; i >= 1; i--) begin
      if (aw_addr_q == C_REG_ADDR_ARRAY[i*C_ADDR_WIDTH +: C_ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_wr  = C_REG_WRAC_ARRAY[i];
        hit_sel = C_NUM_REG_WIDTH'(i);
      end
    end
  end

  assign resp     = (hit & hit_wr) ? 2'b00 : 2'b10;
  assign do_write = commit & hit & hit_wr & (|w_strb_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (awvalid && !aw_full) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (wvalid && !w_full) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < C_BQ_DEPTH; i++) bq_mem[i] <= 2'b00;
    end else begin
      if (commit) begin
        bq_mem[wr_ptr[PW-2:0]] <= resp;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_data_write <= 1'b0;
      reg_data_sel   <= '0;
      reg_data       <= '0;
      reg_data_strb  <= '0;
    end else begin
      reg_data_write <= do_write;
      if (do_write) begin
        reg_data_sel  <= hit_sel;
        reg_data      <= w_data_q;
        reg_data_strb <= w_strb_q;
      end
    end
  end

endmodule

// File: tb/tb_axi_ctrl_write_queue.sv
// Directed bench for axi_ctrl_write_queue with a write/response
// scoreboard checked by a negedge monitor.
module tb_axi_ctrl_write_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [2:0]  reg_data_sel;
  logic        reg_data_write;
  logic [31:0] reg_data;
  logic [3:0]  reg_data_strb;

  localparam logic [4:0] WRAC = 5'b11101;

  axi_ctrl_write_queue #(
    .C_REG_WRAC_ARRAY(WRAC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .reg_data_sel(reg_data_sel), .reg_data_write(reg_data_write),
    .reg_data(reg_data), .reg_data_strb(reg_data_strb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_wr[$];
  logic [1:0] exp_b[$];
  wr_t  mon_e;
  bit   ok;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] slot_of(logic [31:0] a);
    case (a)
      32'h0000_F000: return 3'd1;
      32'h0000_F004: return 3'd2;
      32'h0000_F008: return 3'd3;
      32'h0000_F00C: return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

  task automatic push_exp(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    logic [2:0] sl;
    bit good;
    sl = slot_of(a);
    good = (sl != 3'd0) && WRAC[sl];
    exp_b.push_back(good ? 2'b00 : 2'b10);
    if (good && s != 4'h0) exp_wr.push_back({sl, d, s});
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int max, output bit acc);
    bit ad = 0;
    bit wd = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < max && !(ad && wd); c++) begin
      @(negedge clk);
      if (awvalid && awready) ad = 1;
      if (wvalid && wready) wd = 1;
      @(posedge clk); #1;
      if (ad) awvalid = 1'b0;
      if (wd) wvalid = 1'b0;
    end
    acc = ad && wd;
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (acc) push_exp(a, d, s);
  endtask

  task automatic wait_drain(int max);
    for (int c = 0; c < max && (exp_wr.size() + exp_b.size()) != 0; c++)
      @(negedge clk);
    chk("drain_pending", 64'(exp_wr.size() + exp_b.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n && reg_data_write === 1'b1) begin
      if (exp_wr.size() == 0) chk("unexpected_write", reg_data_write, 0);
      else begin
        mon_e = exp_wr.pop_front();
        chk("write", {reg_data_sel, reg_data, reg_data_strb}, mon_e);
      end
    end
    if (reset_n && bvalid === 1'b1 && bready === 1'b1) begin
      if (exp_b.size() == 0) chk("unexpected_b", bvalid, 0);
      else chk("bresp", bresp, exp_b.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    awvalid = 1'b0; awaddr = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_write", reg_data_write, 0);
    chk("rst_sel", reg_data_sel, 0);
    chk("rst_data", reg_data, 0);
    chk("rst_strb", reg_data_strb, 0);
    chk("rst_bresp", bresp, 0);

    // simultaneous AW+W, latency 2
    bready = 1'b1;
    @(posedge clk); #1;
    awaddr = 32'hF004; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("n0_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    push_exp(32'hF004, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("n1_write", reg_data_write, 0);
    chk("n1_bvalid", bvalid, 0);
    @(negedge clk);
    chk("n2_write", reg_data_write, 1);
    chk("n2_sel", reg_data_sel, 2);
    chk("n2_data", reg_data, 32'hDEADBEEF);
    chk("n2_bvalid", bvalid, 1);
    chk("n2_bresp", bresp, 0);
    @(negedge clk);
    chk("n3_write", reg_data_write, 0);
    wait_drain(20);

    // W first, AW three cycles later
    @(posedge clk); #1;
    awaddr = 32'hF008; wdata = 32'h1234_5678; wstrb = 4'hF;
    wvalid = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    chk("w_held_wready", wready, 0);
    chk("w_held_awready", awready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    push_exp(32'hF008, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("n4_write", reg_data_write, 0);
    @(negedge clk);
    chk("n5_write", reg_data_write, 1);
    chk("n5_sel", reg_data_sel, 3);
    wait_drain(20);

    // decode errors, read-only slot, strobe cases
    send(32'h1234, 32'hAAAA5555, 4'hF, 20, ok); chk("acc_nomatch", ok, 1);
    send(32'hF000, 32'h0BAD0BAD, 4'hF, 20, ok); chk("acc_ro", ok, 1);
    send(32'hF00C, 32'h11112222, 4'h0, 20, ok); chk("acc_strb0", ok, 1);
    send(32'hF00C, 32'h0F0F0F0F, 4'h5, 20, ok); chk("acc_strb5", ok, 1);
    wait_drain(30);

    // backpressure: depth 4 plus one held pair
    bready = 1'b0;
    send(32'hF004, 32'h0000_0001, 4'hF, 10, ok); chk("bp_acc0", ok, 1);
    send(32'h1234, 32'h0000_0002, 4'hF, 10, ok); chk("bp_acc1", ok, 1);
    send(32'hF008, 32'h0000_0003, 4'h3, 10, ok); chk("bp_acc2", ok, 1);
    send(32'hF00C, 32'h0000_0004, 4'hF, 10, ok); chk("bp_acc3", ok, 1);
    send(32'hF000, 32'h0000_0005, 4'hF, 10, ok); chk("bp_acc4", ok, 1);
    send(32'hF004, 32'h0000_0006, 4'hF, 8, ok);  chk("bp_sixth", ok, 0);
    @(negedge clk);
    chk("bp_awready", awready, 0);
    chk("bp_wready", wready, 0);
    chk("bp_bvalid", bvalid, 1);
    chk("bp_bresp_head", bresp, 0);
    @(posedge clk); #1 bready = 1'b1;
    send(32'hF004, 32'h0000_0006, 4'hF, 20, ok); chk("bp_sixth_late", ok, 1);
    wait_drain(40);

    // reset with a held AW and two queued responses
    bready = 1'b0;
    send(32'hF004, 32'h0000_00A1, 4'hF, 10, ok); chk("rs_acc0", ok, 1);
    send(32'hF008, 32'h0000_00A2, 4'hF, 10, ok); chk("rs_acc1", ok, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 awaddr = 32'hF00C; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    chk("rs_pre_awready", awready, 0);
    chk("rs_pre_bvalid", bvalid, 1);
    reset_n = 1'b0;
    #1;
    chk("rs_bvalid", bvalid, 0);
    chk("rs_awready", awready, 1);
    chk("rs_wready", wready, 1);
    exp_wr.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; bready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rs_post_write", reg_data_write, 0);
      chk("rs_post_bvalid", bvalid, 0);
    end
    send(32'hF00C, 32'hCAFEF00D, 4'h9, 10, ok); chk("rs_post_acc", ok, 1);
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_ctrl_write_queue.md
AXI_CTRL_WRITE_QUEUE -- requirements
Module: axi_ctrl_write_queue

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, data width, a multiple of 8.
REQ-003 SHALL have parameter C_NUM_REG, default 5, number of register slots; slot 0 is the no-match slot.
REQ-004 SHALL have parameter C_NUM_REG_WIDTH, default 3, width of the slot index.
REQ-005 SHALL have parameter C_REG_ADDR_ARRAY, default 160'h0000_f00C_0000_f008_0000_f004_0000_f000_FFFF_FFFF, one C_ADDR_WIDTH address per slot, slot i at bits [i*C_ADDR_WIDTH +: C_ADDR_WIDTH].
REQ-006 SHALL have parameter C_REG_WRAC_ARRAY, default 5'b11111, bit i = 1 when slot i is writable.
REQ-007 SHALL have parameter C_BQ_DEPTH, default 4, B-response queue depth, a power of 2 and at least 2.
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports awvalid/awready/awaddr (in/out/in, 1/1/C_ADDR_WIDTH), the AXI write-address channel.
REQ-011 SHALL have ports wvalid/wready/wdata/wstrb (in/out/in/in, 1/1/C_DATA_WIDTH/C_DATA_WIDTH/8), the AXI write-data channel.
REQ-012 SHALL have ports bvalid/bready/bresp (out/in/out, 1/1/2), the AXI write-response channel.
REQ-013 SHALL have outputs reg_data_sel (C_NUM_REG_WIDTH), reg_data_write (1), reg_data (C_DATA_WIDTH) and reg_data_strb (C_DATA_WIDTH/8), the register-bank write port.

Function
REQ-014 SHALL hold one AW entry (aw_full, address) and one W entry (w_full, data, strb), filled independently in either order.
REQ-015 SHALL drive awready = ~aw_full and wready = ~w_full, both taken straight from registers with no combinational path from any input.
REQ-016 SHALL set aw_full on an AW handshake and w_full on a W handshake; both may be captured in the same cycle.
REQ-017 SHALL commit in any cycle where aw_full & w_full & ~bq_full, and that commit SHALL clear both entries.
REQ-018 SHALL decode at commit: the lowest slot i >= 1 whose address exactly equals the held address; if none matches, slot 0.
REQ-019 SHALL give each commit a response: slot 0 -> bresp 2'b10 (SLVERR), no write; matched slot with WRAC bit 0 -> SLVERR, no write; otherwise 2'b00 (OKAY).
REQ-020 SHALL treat an all-zero strb on an OKAY commit as OKAY with no write pulse.
REQ-021 SHALL, on the cycle after a writing commit, pulse reg_data_write high for exactly one cycle with reg_data_sel/reg_data/reg_data_strb registered; those outputs SHALL hold their values otherwise.
REQ-022 SHALL push the response into the BQ at the commit edge.
REQ-023 SHALL drive bvalid = BQ not empty and bresp = BQ head, and SHALL pop the BQ on bvalid & bready.
REQ-024 SHALL give a latency of 2 cycles from simultaneous AW+W handshake (cycle N) to reg_data_write and bvalid (cycle N+2).
REQ-025 SHALL sustain a throughput of one write every 2 cycles when bready is held high.
REQ-026 SHALL NOT commit while the BQ is full, even if a pop occurs in the same cycle; the commit follows on the next cycle.
REQ-027 SHALL allow a push and a pop in the same cycle when the BQ is not full, leaving the count unchanged.
REQ-028 SHALL use BQ pointers of width log2(C_BQ_DEPTH)+1 that wrap modulo 2*C_BQ_DEPTH; full when the MSBs differ and the rest are equal.
REQ-029 SHALL keep responses in commit order.
REQ-030 SHALL accept at most C_BQ_DEPTH+1 transactions before any B pop: C_BQ_DEPTH queued plus one held pair.
REQ-031 SHALL keep bvalid and bresp stable while bvalid & ~bready.

Reset
REQ-032 SHALL, on reset_n low, immediately clear aw_full, w_full, BQ pointers and reg_data_write, giving awready=1, wready=1, bvalid=0.
REQ-033 SHALL reset reg_data_sel, reg_data and reg_data_strb to 0 and bresp to 2'b00.
REQ-034 SHALL discard in-flight held entries and queued responses when reset is asserted mid-operation, with no write pulse afterwards.
REQ-035 SHALL release reset synchronously to clk, ready to accept on the first edge after release.

Verification
REQ-036 SHALL check: AW+W together at cycle N, awaddr=0xF004, wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> reg_data_write at N+2, sel=2, data=0xDEADBEEF, bresp=00 with bvalid at N+2.
REQ-037 SHALL check: W at cycle N, AW at N+3 (addr 0xF008) -> W is held, commit at N+4, write at N+5 with sel=3.
REQ-038 SHALL check: awaddr=0x1234 -> no reg_data_write, bresp=2'b10; C_REG_WRAC_ARRAY bit 1 = 0 with addr 0xF000 -> bresp=2'b10, no write.
REQ-039 SHALL check: bready=0 with 6 transactions offered at C_BQ_DEPTH=4 -> 5 AW/W accepted, awready=wready=0 afterwards; then bready=1 -> 6 responses in order, no loss.
REQ-040 SHALL check: wstrb=0x0 to 0xF00C -> bresp=00, no reg_data_write; wstrb=0x5 -> reg_data_strb=0x5.
REQ-041 SHALL check: reset_n pulsed low with aw_full=1 and 2 queued responses -> bvalid=0, awready=1 the same cycle, no write pulse after release.
